// File: rtl/tbs_pkg.sv
// Shared constants and types for the TBS link (receiver side and transmitter).
// TBS_BIT_CLKS is the bit period both ends must agree on.
package tbs_pkg;

  localparam int TBS_BIT_CLKS  = 434;
  localparam int TBS_MIN_PULSE = 4;
  localparam int DATA_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

endpackage

// File: rtl/tbs_rx_if.sv
// Receiver-side bundle: the TBS line in, decoded bytes and status out.
interface tbs_rx_if;
  import tbs_pkg::*;

  // rx_valid is a one-cycle strobe with no ready: the consumer must take every
  // strobe, and rx_data/rx_frame_err are only meaningful (and only change) with it.
  logic              TBS_in;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              rx_busy;
  rx_state_t         dbg_state;

  modport master (
    input  TBS_in,
    output rx_data, rx_valid, rx_frame_err, rx_busy, dbg_state
  );

  modport slave (
    output TBS_in,
    input  rx_data, rx_valid, rx_frame_err, rx_busy, dbg_state
  );

endinterface

// File: rtl/tbs_pulse_filter.sv
// Synchronizes the asynchronous TBS line and turns each low pulse of at least
// MIN_PULSE samples into exactly one single-cycle event.
module tbs_pulse_filter
  import tbs_pkg::*;
#(
  parameter int MIN_PULSE = TBS_MIN_PULSE
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic i_line,
  output logic o_pulse_evt
);

  localparam int             CW      = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MIN_PULSE);
  localparam logic [CW-1:0]  CNT_ARM = CW'(MIN_PULSE - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_low_cnt;
  logic          r_pulse_evt;

  // Saturating counter means a long pulse can only cross the threshold once.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b11;
      r_low_cnt   <= '0;
      r_pulse_evt <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_line};
      r_pulse_evt <= 1'b0;
      if (r_sync[1]) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt != CNT_MAX) begin
        r_low_cnt   <= r_low_cnt + 1'b1;
        r_pulse_evt <= (r_low_cnt == CNT_ARM);
      end
    end
  end

  assign o_pulse_evt = r_pulse_evt;

endmodule

// File: rtl/tbs_rx.sv
// TBS receiver: rebuilds UART-format bytes from the pulse-per-zero TBS line,
// strobing each byte out with a framing-error flag.
module tbs_rx
  import tbs_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int BIT_CLKS  = TBS_BIT_CLKS,
  parameter int MIN_PULSE = TBS_MIN_PULSE
) (
  input logic     clk_50M,
  input logic     rst_n,
  tbs_rx_if.master bus
);

  localparam int            BW        = $clog2(BIT_CLKS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] STOP_LOAD = BW'(BIT_CLKS / 2 - 2);
  localparam logic [BW-1:0] STOP_LAST = BW'(BIT_CLKS / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd8;

  // CLK_FREQ/BAUD_RATE only document the nominal rate; BIT_CLKS times the frame.
  if (CLK_FREQ < BAUD_RATE || BIT_CLKS < 2 * MIN_PULSE) begin : g_cfg_suspect
  end

  logic              w_pulse_evt;
  logic              w_wrap;
  rx_state_t         r_state;
  logic [BW-1:0]     r_baud_cnt;
  logic [3:0]        r_bit_cnt;
  logic              r_zero_flag;
  logic              r_err_flag;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_frame_err;
  logic              r_rx_busy;

  tbs_pulse_filter #(.MIN_PULSE(MIN_PULSE)) u_filter (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .i_line      (bus.TBS_in),
    .o_pulse_evt (w_pulse_evt)
  );

  assign w_wrap = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_baud_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_zero_flag    <= 1'b0;
      r_err_flag     <= 1'b0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pulse_evt) begin
            r_state     <= DATA;
            r_bit_cnt   <= '0;
            r_baud_cnt  <= '0;
            r_zero_flag <= 1'b0;
            r_rx_busy   <= 1'b1;
          end
        end
        DATA: begin
          if (w_wrap) begin
            r_baud_cnt  <= '0;
            r_bit_cnt   <= r_bit_cnt + 4'd1;
            r_zero_flag <= 1'b0;
            // Window 0 is the start bit; a pulse on the wrap cycle still counts.
            if (r_bit_cnt != 4'd0)
              r_shift <= {~(r_zero_flag | w_pulse_evt), r_shift[DATA_W-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_state    <= STOP;
              r_err_flag <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
            if (w_pulse_evt && r_bit_cnt != 4'd0)
              r_zero_flag <= 1'b1;
          end
        end
        STOP: begin
          r_baud_cnt <= r_baud_cnt + 1'b1;
          if (w_pulse_evt)
            r_err_flag <= 1'b1;
          // Outputs load one cycle early so the strobe lands on the last stop-window cycle.
          if (r_baud_cnt == STOP_LOAD) begin
            r_rx_valid     <= 1'b1;
            r_rx_data      <= r_shift;
            r_rx_frame_err <= r_err_flag | w_pulse_evt;
          end
          if (r_baud_cnt == STOP_LAST) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_rx_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_frame_err = r_rx_frame_err;
  assign bus.rx_busy      = r_rx_busy;
  assign bus.dbg_state    = r_state;

endmodule

// File: doc/tbs_rx.md
# tbs_rx

TBS bus receiver: decodes the pulse-encoded TBS line (idle high, one low pulse per '0' bit, start bit included) back into 8-bit UART-format bytes. It is the downstream counterpart of the TBS transmitter, on the far end of the TBS wire. Each received byte is presented with a one-cycle valid strobe and a framing-error flag. The block has no backpressure: the consumer must accept every strobe.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz (documentation only).
- BAUD_RATE, 115200, line bit rate (documentation only).
- BIT_CLKS, 434, clock cycles per bit period; must match the transmitter's bit period.
- MIN_PULSE, 4, consecutive low samples required to accept a pulse; must be well below the 43-cycle TX pulse width.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- TBS_in  in  1  TBS line, asynchronous to the clock, idle high.
- rx_data  out  8  last received byte, LSB first on the wire; held until the next valid.
- rx_valid  out  1  one-cycle strobe: rx_data and rx_frame_err are valid.
- rx_frame_err  out  1  set with rx_valid when a pulse appeared in the stop window; held until the next valid.
- rx_busy  out  1  high while a frame is being received (state not IDLE).

## Operation
- **Input conditioning:** TBS_in passes through a 2-flop synchronizer, then a glitch filter.
  - low_cnt counts consecutive low synchronized samples, saturating at MIN_PULSE, and clears on any high sample.
  - pulse_evt is a single cycle, asserted when low_cnt steps from MIN_PULSE-1 to MIN_PULSE.
  - Exactly one pulse_evt is produced per low pulse, whatever its width.
- **State machine:** IDLE, DATA, STOP.
- **IDLE:** pulse_evt → DATA, with bit_cnt←0 and baud_cnt←0. This pulse is the start bit.
- **DATA:**
  - baud_cnt counts 0..BIT_CLKS-1 and wraps; bit_cnt increments on each wrap.
  - bit_cnt=0 is the start window. Pulses there are ignored.
  - bit_cnt=k (1..8) is the window for data bit k-1. Any pulse_evt in the window, including one on its last cycle, sets zero_flag.
  - On wrap, rx_data bit k-1 ← ~zero_flag (shift register, LSB first), and zero_flag clears.
  - When bit 8's window wraps → STOP, with baud_cnt←0.
- **STOP:**
  - Lasts only the first half of the stop bit (baud_cnt 0..BIT_CLKS/2-1). Ending at mid-bit keeps the next frame's start pulse, which arrives at the stop-bit end, from landing in the stop window.
  - A pulse_evt in STOP sets err_flag.
  - At baud_cnt = BIT_CLKS/2-1, the block registers rx_data and rx_frame_err ← err_flag, pulses rx_valid, and returns to IDLE.
- **Arithmetic:**
  - baud_cnt width is $clog2(BIT_CLKS).
  - bit_cnt is 4 bits.
  - All compares are unsigned.
  - BIT_CLKS/2 uses integer division.
- **Reset, including mid-frame:** state IDLE, counters 0, rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_busy 0. Synchronizer flops reset to 1. A partially received frame is discarded and produces no valid.

## Timing
- Event latency: pulse_evt is asserted MIN_PULSE+2 cycles after the TBS_in falling edge (2 for sync, MIN_PULSE for the filter).
- Frame latency: with E as the start pulse_evt cycle, rx_valid is high exactly in cycle E + 9·BIT_CLKS + BIT_CLKS/2. rx_busy is high from E+1 through that cycle.
- Back-to-back frames: the next start pulse_evt may occur as early as the cycle after rx_valid and must be accepted.
- Data pulses: the transmitter places data pulses about 10 cycles into each bit. After the same sync and filter delay, they land at baud_cnt ≈10, far from the window edges.
- rx_data and rx_frame_err change only in the rx_valid cycle.

## Structure
- **Package tbs_pkg:** BIT_CLKS default, MIN_PULSE default, the state enum {IDLE, DATA, STOP}, and the data width constant 8. The transmitter shares the BIT_CLKS constant.
- **Sub-module tbs_pulse_filter:** synchronizer plus low_cnt plus pulse_evt generation, parameterized by MIN_PULSE. The top level holds the FSM and counters. Total RTL is about 150–200 lines.

## Test plan
- **0x55:** send via a TBS transmitter model (pulses on start, b1, b3, b5, b7) → one rx_valid, rx_data=8'h55, rx_frame_err=0, in cycle E+9·434+217.
- **0x00 and 0xFF:** 0x00 gives 9 pulses; 0xFF gives only the start pulse → rx_data 8'h00 then 8'hFF, no errors.
- **Glitch rejection:** a 2-cycle low glitch on an idle line → rx_busy stays 0, no rx_valid. A 3-cycle glitch inside a data window of 0xFF → data still 8'hFF.
- **Framing error:** byte 0xA3 plus an extra 43-cycle pulse at stop-bit offset 50 → rx_data=8'hA3, rx_frame_err=1. A following clean byte 0x3C clears the flag to 0.
- **Back-to-back:** 16 frames with zero idle gap (random bytes, BIT_CLKS=434) → 16 strobes, all bytes match, no errors, no missed start.
- **Reset mid-frame:** rst_n low during bit 4 of 0x81, released, then 0x7E sent → no strobe for 0x81, outputs at reset values, rx_data=8'h7E afterwards.
